// File: rtl/instru_fetch_queue.sv
// Instruction fetch queue for the pipelined IF stage.
// A synchronous-read program memory feeds a small FIFO toward ID.
// The fetch PC runs ahead on its own and stalls only on queue credit.
// It stops on the all-ones opcode sentinel or when the PC leaves the array.
// A redirect flushes the queue and restarts fetch at a new PC.
module instru_fetch_queue #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = 'hFC000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instru,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [5:0]               out_ctr,
  output logic [5:0]               out_funcode,
  output logic                     fault,
  output logic                     busy
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Program memory and its registered read data
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Fetch engine state
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] rd_pc_reg;
  logic              rd_pending_reg;
  logic              rd_oor_reg;
  logic              halted_reg;
  logic              fault_reg;
  logic [ADDR_W-1:0] last_pc_reg;

  // Fetch queue
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              pc_oor;
  logic [MEM_AW-1:0] rd_idx;
  logic              push;
  logic              pop;
  logic              issue;
  logic              halt_hit;
  logic [DATA_W-1:0] push_word;
  logic [CNT_W-1:0]  occupancy;

  // Issue/push/pop decisions; a redirect overrides all queue traffic
  always_comb begin
    pc_oor    = ({2'b00, pc_reg[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
    rd_idx    = pc_reg[MEM_AW+1:2];
    push      = rd_pending_reg & ~redirect_valid;
    push_word = rd_oor_reg ? NOP_WORD : rdata_reg;
    // Sentinel on the word being pushed blocks any issue in the same cycle
    halt_hit  = push & (push_word[31:26] == 6'h3F);
    occupancy = count_reg + CNT_W'(rd_pending_reg);
    busy      = rst_n & ~halted_reg;
    issue     = busy & ~halt_hit & ~redirect_valid & (occupancy < CNT_W'(FIFO_DEPTH));
    out_valid = (count_reg != '0);
    pop       = out_valid & out_ready & ~redirect_valid;
  end

  // Loader write and fetch read; the read sees pre-write contents
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (issue)   rdata_reg <= mem[rd_idx];
  end

  // Queue storage, one register slot per entry
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == PTR_W'(gi)) begin
        q_data[gi] <= push_word;
        q_pc[gi]   <= rd_pc_reg;
      end
    end
  end

  // Fetch PC, pending read, halt/fault flags and queue pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= '0;
      rd_pc_reg      <= '0;
      rd_pending_reg <= 1'b0;
      rd_oor_reg     <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      last_pc_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else if (redirect_valid) begin
      pc_reg         <= redirect_pc & ~ADDR_W'(3);
      rd_pending_reg <= 1'b0;
      rd_oor_reg     <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      rd_pending_reg <= issue;
      if (issue) begin
        rd_pc_reg  <= pc_reg;
        rd_oor_reg <= pc_oor;
        pc_reg     <= pc_reg + ADDR_W'(4);
        if (pc_oor) begin
          fault_reg  <= 1'b1;
          halted_reg <= 1'b1;
        end
      end
      if (halt_hit) halted_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        last_pc_reg <= q_pc[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head presentation; an empty queue shows the sentinel and the last popped PC
  always_comb begin
    out_instru  = out_valid ? q_data[rd_ptr_reg] : NOP_WORD;
    out_pc      = out_valid ? q_pc[rd_ptr_reg] : last_pc_reg;
    out_ctr     = out_instru[31:26];
    out_funcode = out_instru[5:0];
    fault       = fault_reg;
  end

endmodule

// File: tb/tb_instru_fetch_queue.sv
// Directed bench for instru_fetch_queue: streaming, backpressure, redirect,
// out-of-range fault, loader read-before-write and asynchronous reset.
module tb_instru_fetch_queue;
  localparam int DATA_W = 32, DEPTH = 128, ADDR_W = 32, FIFO_DEPTH = 4;
  localparam logic [31:0] NOP = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [6:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instru;
  logic [31:0] out_pc;
  logic [5:0]  out_ctr;
  logic [5:0]  out_funcode;
  logic        fault;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prog [5] = '{32'h20080001, 32'h20080002, 32'h20080003, 32'h20080004, 32'hFC000000};

  instru_fetch_queue #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instru(out_instru), .out_pc(out_pc), .out_ctr(out_ctr),
    .out_funcode(out_funcode), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called right after a negedge; returns after the next negedge
  task automatic load_word(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = 7'(a); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] p);
    redirect_valid = 1'b1; redirect_pc = p;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < DEPTH; i++) load_word(i, NOP);
    for (int i = 0; i < 5; i++) load_word(i, prog[i]);
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_instru !== NOP) begin n_err++; $display("FAIL reset_instru got %h want %h", out_instru, NOP); end
    n_cmp++;
    if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", out_pc); end
    n_cmp++;
    if (out_ctr !== 6'h3F || out_funcode !== 6'h00) begin
      n_err++; $display("FAIL reset_fields got ctr=%h fn=%h want 3f/00", out_ctr, out_funcode);
    end
    n_cmp++;
    if (busy !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL reset_busy_fault got busy=%b fault=%b want 0/0", busy, fault);
    end
    n_cmp++;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    if (busy !== 1'b1) begin n_err++; $display("FAIL release_busy got %b want 1", busy); end
    n_cmp++;
    @(negedge clk);
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_1st_edge got valid=%b want 0", out_valid); end
    n_cmp++;
  endtask

  task automatic test_stream;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("stream pop pc=%h instru=%h busy=%b", out_pc, out_instru, busy);
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instru !== prog[k]) begin
        n_err++; $display("FAIL stream_k%0d got v=%b pc=%h ins=%h want 1/%h/%h", k, out_valid, out_pc, out_instru, 32'(4*k), prog[k]);
      end
      n_cmp++;
      if (busy !== (k < 4)) begin n_err++; $display("FAIL stream_busy_k%0d got %b want %b", k, busy, (k < 4)); end
      n_cmp++;
    end
    if (out_ctr !== 6'h3F) begin n_err++; $display("FAIL stream_last_ctr got %h want 3f", out_ctr); end
    n_cmp++;
    @(negedge clk);
    if (out_valid !== 1'b0 || out_pc !== 32'h10 || out_instru !== NOP) begin
      n_err++; $display("FAIL stream_empty got v=%b pc=%h ins=%h want 0/10/%h", out_valid, out_pc, out_instru, NOP);
    end
    n_cmp++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    redirect_to(32'h0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instru !== prog[0] || busy !== 1'b1) begin
          n_err++; $display("FAIL stall_hold_i%0d got v=%b pc=%h ins=%h busy=%b want 1/0/%h/1", i, out_valid, out_pc, out_instru, busy, prog[0]);
        end
        n_cmp++;
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      $display("drain pop pc=%h instru=%h", out_pc, out_instru);
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instru !== prog[k]) begin
        n_err++; $display("FAIL drain_k%0d got v=%b pc=%h ins=%h want 1/%h/%h", k, out_valid, out_pc, out_instru, 32'(4*k), prog[k]);
      end
      n_cmp++;
      @(negedge clk);
    end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", out_valid); end
    n_cmp++;
  endtask

  task automatic test_redirect_pop;
    out_ready = 1'b1;
    redirect_to(32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      n_err++; $display("FAIL redir_pre got v=%b pc=%h want 1/4", out_valid, out_pc);
    end
    n_cmp++;
    redirect_to(32'h0000000B);
    if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
      n_err++; $display("FAIL redir_flush got v=%b pc=%h want 0/0", out_valid, out_pc);
    end
    n_cmp++;
    @(negedge clk);
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap got %b want 0", out_valid); end
    n_cmp++;
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      $display("redirect pop pc=%h instru=%h", out_pc, out_instru);
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instru !== prog[k]) begin
        n_err++; $display("FAIL redir_k%0d got v=%b pc=%h ins=%h want 1/%h/%h", k, out_valid, out_pc, out_instru, 32'(4*k), prog[k]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_out_of_range;
    out_ready = 1'b1;
    load_word(DEPTH-1, 32'h20080080);
    redirect_to(32'(4*(DEPTH-1)));
    @(negedge clk);
    @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'(4*(DEPTH-1)) || out_instru !== 32'h20080080) begin
      n_err++; $display("FAIL oor_last got v=%b pc=%h ins=%h want 1/%h/20080080", out_valid, out_pc, out_instru, 32'(4*(DEPTH-1)));
    end
    n_cmp++;
    @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'(4*DEPTH) || out_instru !== NOP || fault !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL oor_nop got v=%b pc=%h ins=%h fault=%b busy=%b want 1/%h/%h/1/0", out_valid, out_pc, out_instru, fault, busy, 32'(4*DEPTH), NOP);
    end
    n_cmp++;
    @(negedge clk);
    if (out_valid !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL oor_sticky got v=%b fault=%b want 0/1", out_valid, fault);
    end
    n_cmp++;
    redirect_to(32'h0);
    if (fault !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL oor_clear got fault=%b busy=%b want 0/1", fault, busy);
    end
    n_cmp++;
  endtask

  task automatic test_loader_rbw;
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    redirect_valid = 1'b0;
    load_en = 1'b1; load_addr = 7'd2; load_data = 32'h2008AAAA;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instru !== 32'h20080003) begin
      n_err++; $display("FAIL rbw_old got v=%b pc=%h ins=%h want 1/8/20080003", out_valid, out_pc, out_instru);
    end
    n_cmp++;
    redirect_to(32'h8);
    @(negedge clk); @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instru !== 32'h2008AAAA) begin
      n_err++; $display("FAIL rbw_new got v=%b pc=%h ins=%h want 1/8/2008aaaa", out_valid, out_pc, out_instru);
    end
    n_cmp++;
    load_word(2, prog[2]);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    redirect_to(32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      n_err++; $display("FAIL areset_pre got v=%b pc=%h want 1/4", out_valid, out_pc);
    end
    n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || out_instru !== NOP || busy !== 1'b0 || out_pc !== 32'h0) begin
      n_err++; $display("FAIL areset_now got v=%b ins=%h busy=%b pc=%h want 0/%h/0/0", out_valid, out_instru, busy, out_pc, NOP);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_lat got %b want 0", out_valid); end
    n_cmp++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instru !== prog[k]) begin
        n_err++; $display("FAIL areset_k%0d got v=%b pc=%h ins=%h want 1/%h/%h", k, out_valid, out_pc, out_instru, 32'(4*k), prog[k]);
      end
      n_cmp++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_pop();
    test_out_of_range();
    test_loader_rbw();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
